ahb_arbiter: RTL and testbench
==============================

// Module: ahb_arbiter
// PURPOSE
//  AHB arbiter for the bus matrix: shares one AHB layer between up to 16 masters.
//  Samples HBUSREQ/HLOCK and drives HGRANT, HMASTER and HMASTLOCK.
//  Holds ownership across fixed-length bursts and locked sequences.
//  Masks split masters until a slave releases them via HSPLIT; with no eligible requester the default master owns the bus.
// PARAMETERS
//  NUM_MASTERS     4   number of masters, 2..16
//  DEFAULT_MASTER  0   index granted at reset and when no eligible request exists
// PORTS
//  HCLK       in   1            bus clock
//  HRESETn    in   1            asynchronous, active-low reset
//  HBUSREQ    in   NUM_MASTERS  bus request, one bit per master
//  HLOCK      in   NUM_MASTERS  locked-access request, one bit per master
//  HTRANS     in   2            transfer type of current address phase
//  HBURST     in   3            burst type of current address phase
//  HREADY     in   1            bus ready from slave mux
//  HRESP      in   2            slave response from slave mux
//  HSPLIT     in   16           OR of all slaves' split-release vectors
//  HGRANT     out  NUM_MASTERS  one-hot grant (registered)
//  HMASTER    out  4            master owning current address phase (registered)
//  HMASTLOCK  out  1            current address phase is locked (registered)
// BEHAVIOUR
//  Reset:
//   - HGRANT = 1<<DEFAULT_MASTER, HMASTER = DEFAULT_MASTER, HMASTLOCK = 0.
//   - beats_left = 0, split_mask = 0, dmaster = DEFAULT_MASTER.
//   - Reset mid-burst/lock/split discards all state immediately.
//  Beat counter beats_left[3:0]:
//   - NONSEQ accepted (HREADY=1) with INCR4/WRAP4 loads 3; INCR8/WRAP8 loads 7; INCR16/WRAP16 loads 15.
//   - NONSEQ accepted with SINGLE/INCR loads 0.
//   - SEQ accepted decrements (floor 0). IDLE accepted clears to 0.
//  Data-phase owner: dmaster <= HMASTER whenever HREADY=1.
//  Re-arbitration enable arb_en (combinational); arb_en = 1 when any of:
//   - HREADY=1, HMASTLOCK=0, HLOCK[owner]=0, and either:
//     - beats_left=0 and not (HTRANS=NONSEQ with fixed-length HBURST), or
//     - HTRANS=SEQ and beats_left=1 (last beat address).
//   - First cycle of an ERROR/SPLIT/RETRY response (HREADY=0, HRESP!=OKAY); this also clears beats_left.
//  Grant selection on arb_en:
//   - Round-robin among eligible requests (HBUSREQ & ~split_mask), searching from HGRANT index+1 and wrapping.
//   - Current owner is considered last, so it keeps the bus if alone.
//   - No eligible request -> DEFAULT_MASTER.
//   - HGRANT updates at the clock edge; with arb_en=0 HGRANT holds.
//  Ownership transfer: on HREADY=1 edge, HMASTER <= index(HGRANT) and HMASTLOCK <= HLOCK[index(HGRANT)].
//   New owner's first address phase is one cycle after its grant is seen with HREADY high.
//  Split:
//   - First SPLIT response cycle (HRESP=SPLIT, HREADY=0) sets split_mask[dmaster].
//   - HSPLIT[i]=1 clears split_mask[i]; set wins over a simultaneous clear of the same bit.
//   - split_mask[DEFAULT_MASTER] is never set. Bits >= NUM_MASTERS are ignored.
//   - All requesters masked -> default master granted.
//  Lock:
//   - While HLOCK of the owner is high, or HMASTLOCK is high, no other master is granted.
//   - A SPLIT/RETRY response ends the lock hold.
// STRUCTURE
//  - Add HBURST encodings (SINGLE..INCR16) and HRESP_RETRY/HRESP_SPLIT to the shared ahb_defines.v package.
//  - One sub-module: ahb_rr_picker (combinational; request vector + last-grant index -> one-hot grant, valid).
//  - Top holds beat counter, split mask, dmaster and output registers.
// TESTING
//  - Reset with HBUSREQ=0 -> HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0; stays so for 10 idle cycles.
//  - M1,M2,M3 request continuously, SINGLE NONSEQ each cycle -> grants rotate 1,2,3,1; HMASTER follows one HREADY edge later.
//  - M2 owns, INCR8 NONSEQ + 7 SEQ, M1 requesting:
//    - HGRANT stays M2 until the 8th address (SEQ, beats_left=1) is accepted;
//    - HMASTER=1 on the following HREADY edge.
//  - M1 HLOCK=1 across two SINGLEs, M3 requesting -> HMASTLOCK=1 for both; M3 granted only after HLOCK falls.
//  - M3 data phase gets SPLIT:
//    - split_mask[3]=1, M3 not granted despite HBUSREQ[3]=1;
//    - HSPLIT=16'h0008 -> M3 granted at next arb_en;
//    - with the mask set and HBUSREQ=4'b1000, M0 is granted.
//  - HRESETn low during an INCR16 at beat 5 -> outputs at reset values immediately; first post-reset NONSEQ re-arbitrates normally.

Source files
------------

// File: rtl/ahb_arbiter_pkg.sv
// Shared AHB encodings and helpers for the bus-matrix arbiter.
// Holds HTRANS/HBURST/HRESP codes and the burst-length lookup.
package ahb_arbiter_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    // Beats still to come after the NONSEQ of a burst.
    function automatic logic [3:0] burst_beats(input logic [2:0] b);
        logic [3:0] r;
        r = 4'd0;
        case (b)
            HBURST_WRAP4,  HBURST_INCR4:  r = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  r = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: r = 4'd15;
            default:                      r = 4'd0;
        endcase
        return r;
    endfunction

    function automatic logic is_fixed(input logic [2:0] b);
        return (b != HBURST_SINGLE) && (b != HBURST_INCR);
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Round-robin picker: searches req_i from last_i+1, wrapping, so last_i is
// checked last. Ports: req_i, last_i in; one-hot gnt_o, idx_o, valid_o out.
module ahb_rr_picker #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req_i,
    input  logic [3:0]   last_i,
    output logic [N-1:0] gnt_o,
    output logic [3:0]   idx_o,
    output logic         valid_o
);

    int unsigned  pos;
    logic [N-1:0] hit;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = 0;
        hit     = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            pos = 32'(last_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            hit = req_i & (N'(1) << pos);
            if (!valid_o && (|hit)) begin
                gnt_o   = hit;
                idx_o   = 4'(pos);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB layer arbiter: round-robin grant with burst/lock hold, split masking
// and default master. In: HCLK, HRESETn, HBUSREQ, HLOCK, HTRANS, HBURST,
// HREADY, HRESP, HSPLIT. Out (registered): HGRANT, HMASTER, HMASTLOCK.
module ahb_arbiter
    import ahb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    input  logic [1:0]             HRESP,
    input  logic [15:0]            HSPLIT,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [3:0]             HMASTER,
    output logic                   HMASTLOCK
);

    localparam logic [NUM_MASTERS-1:0] DEF_OH =
        NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [3:0] DEF_IDX = 4'(DEFAULT_MASTER);

    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [3:0]             gidx_q, gidx_d;
    logic [3:0]             hmaster_q;
    logic                   hmastlock_q;
    logic [3:0]             beats_q, beats_d;
    logic [NUM_MASTERS-1:0] split_q, split_d;
    logic [3:0]             dmaster_q;
    logic                   err_q;

    logic                   owner_lock;
    logic                   resp_err;
    logic                   resp_first;
    logic                   resp_release;
    logic                   open_slot;
    logic                   last_beat;
    logic                   arb_en;
    logic                   lock_hold;
    logic [NUM_MASTERS-1:0] split_set;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [3:0]             pick_idx;
    logic                   pick_valid;
    logic                   unused_hsplit;

    assign unused_hsplit = ^HSPLIT;

    assign owner_lock =
        |(HLOCK & (NUM_MASTERS'(1) << hmaster_q));

    // Two-cycle responses: only the HREADY-low cycle that follows a
    // non-error cycle counts as the first one.
    assign resp_err   = !HREADY && (HRESP != HRESP_OKAY);
    assign resp_first = resp_err && !err_q;
    assign resp_release = resp_first &&
        ((HRESP == HRESP_SPLIT) || (HRESP == HRESP_RETRY));

    assign open_slot = (beats_q == 4'd0) &&
        !((HTRANS == HTRANS_NONSEQ) && is_fixed(HBURST));
    assign last_beat = (HTRANS == HTRANS_SEQ) && (beats_q == 4'd1);

    assign arb_en = resp_first ||
        (HREADY && !hmastlock_q && !owner_lock &&
         (open_slot || last_beat));

    assign lock_hold = (hmastlock_q || owner_lock) && !resp_release;

    assign split_set = (resp_first && (HRESP == HRESP_SPLIT)) ?
        ((NUM_MASTERS'(1) << dmaster_q) & ~DEF_OH) : '0;

    // Set wins over a same-cycle release of the same master.
    assign split_d = (split_q & ~HSPLIT[NUM_MASTERS-1:0]) | split_set;

    // Eligibility uses the updated mask so a master being split now
    // cannot win the arbitration triggered by its own split.
    ahb_rr_picker #(
        .N(NUM_MASTERS)
    ) u_pick (
        .req_i  (HBUSREQ & ~split_d),
        .last_i (gidx_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .valid_o(pick_valid)
    );

    always_comb begin
        grant_d = grant_q;
        gidx_d  = gidx_q;
        if (arb_en && !lock_hold) begin
            if (pick_valid) begin
                grant_d = pick_gnt;
                gidx_d  = pick_idx;
            end else begin
                grant_d = DEF_OH;
                gidx_d  = DEF_IDX;
            end
        end
    end

    always_comb begin
        beats_d = beats_q;
        if (resp_first) begin
            beats_d = 4'd0;
        end else if (HREADY) begin
            case (HTRANS)
                HTRANS_NONSEQ: beats_d = burst_beats(HBURST);
                HTRANS_SEQ:
                    beats_d = (beats_q == 4'd0) ? 4'd0 : beats_q - 4'd1;
                HTRANS_IDLE:   beats_d = 4'd0;
                default:       beats_d = beats_q;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q     <= DEF_OH;
            gidx_q      <= DEF_IDX;
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
            beats_q     <= 4'd0;
            split_q     <= '0;
            dmaster_q   <= DEF_IDX;
            err_q       <= 1'b0;
        end else begin
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            beats_q <= beats_d;
            split_q <= split_d;
            err_q   <= resp_err;
            if (HREADY) begin
                dmaster_q   <= hmaster_q;
                hmaster_q   <= gidx_q;
                hmastlock_q <= |(HLOCK & grant_q);
            end
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboard bench for ahb_arbiter: a rule-level model predicts the
// registered outputs each cycle; a monitor compares on the falling edge.
module tb_ahb_arbiter;

    localparam int N   = 4;
    localparam int DEF = 0;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [3:0]  HBUSREQ = '0;
    logic [3:0]  HLOCK = '0;
    logic [1:0]  HTRANS = '0;
    logic [2:0]  HBURST = '0;
    logic        HREADY = 1'b1;
    logic [1:0]  HRESP = '0;
    logic [15:0] HSPLIT = '0;
    logic [3:0]  HGRANT;
    logic [3:0]  HMASTER;
    logic        HMASTLOCK;

    ahb_arbiter #(
        .NUM_MASTERS   (N),
        .DEFAULT_MASTER(DEF)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HBUSREQ  (HBUSREQ),
        .HLOCK    (HLOCK),
        .HTRANS   (HTRANS),
        .HBURST   (HBURST),
        .HREADY   (HREADY),
        .HRESP    (HRESP),
        .HSPLIT   (HSPLIT),
        .HGRANT   (HGRANT),
        .HMASTER  (HMASTER),
        .HMASTLOCK(HMASTLOCK)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        int gnt;
        int mst;
        int lck;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state, tracked as plain integers.
    int   m_g = DEF;
    int   m_m = DEF;
    int   m_dm = DEF;
    int   m_beats = 0;
    bit   m_ml = 0;
    bit   m_errprev = 0;
    bit   m_mask [N];
    int   blen [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_g = DEF;
        m_m = DEF;
        m_dm = DEF;
        m_beats = 0;
        m_ml = 0;
        m_errprev = 0;
        for (int i = 0; i < N; i++) m_mask[i] = 0;
    endtask

    function automatic exp_t mk(input int g, input int m, input int l);
        exp_t e;
        e.gnt = 1 << g;
        e.mst = m;
        e.lck = l;
        return e;
    endfunction

    always @(negedge HRESETn) begin
        model_reset();
        sb_q.delete();
    end

    always @(posedge HCLK) begin
        bit rf;
        bit rel;
        bit hold;
        bit arb;
        bit fixd;
        bit nm [N];
        int ng;
        int c;
        if (!HRESETn) begin
            sb_q.push_back(mk(DEF, DEF, 0));
        end else begin
            rf = !HREADY && HRESP != 0 && !m_errprev;
            rel = rf && (HRESP == 2 || HRESP == 3);
            hold = (m_ml || HLOCK[m_m]) && !rel;
            fixd = blen[HBURST] > 1;
            arb = rf;
            if (HREADY && !m_ml && !HLOCK[m_m]) begin
                if (m_beats == 0 && !(HTRANS == 2 && fixd)) arb = 1;
                if (HTRANS == 3 && m_beats == 1) arb = 1;
            end
            for (int i = 0; i < N; i++) begin
                if (rf && HRESP == 3 && i == m_dm && i != DEF)
                    nm[i] = 1;
                else if (HSPLIT[i])
                    nm[i] = 0;
                else
                    nm[i] = m_mask[i];
            end
            ng = m_g;
            if (arb && !hold) begin
                ng = DEF;
                for (int k = N; k >= 1; k--) begin
                    c = (m_g + k) % N;
                    if (HBUSREQ[c] && !nm[c]) ng = c;
                end
            end
            if (rf) m_beats = 0;
            else if (HREADY) begin
                if (HTRANS == 2) m_beats = blen[HBURST] - 1;
                else if (HTRANS == 3)
                    m_beats = (m_beats > 0) ? m_beats - 1 : 0;
                else if (HTRANS == 0) m_beats = 0;
            end
            if (HREADY) begin
                m_dm = m_m;
                m_ml = HLOCK[m_g];
                m_m = m_g;
            end
            m_g = ng;
            for (int i = 0; i < N; i++) m_mask[i] = nm[i];
            m_errprev = !HREADY && HRESP != 0;
            sb_q.push_back(mk(m_g, m_m, m_ml));
        end
    end

    always @(negedge HCLK) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("HGRANT", int'(HGRANT), e.gnt);
            check("HMASTER", int'(HMASTER), e.mst);
            check("HMASTLOCK", int'(HMASTLOCK), e.lck);
        end
    end

    task automatic drv(input logic [3:0] rq, input logic [3:0] lk,
                       input logic [1:0] tr, input logic [2:0] bu,
                       input logic rdy, input logic [1:0] rs,
                       input logic [15:0] sp);
        @(negedge HCLK);
        HBUSREQ = rq;
        HLOCK = lk;
        HTRANS = tr;
        HBURST = bu;
        HREADY = rdy;
        HRESP = rs;
        HSPLIT = sp;
    endtask

    task automatic idle(input logic [3:0] rq, input int n);
        for (int i = 0; i < n; i++) drv(rq, 0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        bit          pend;
        logic [1:0]  prs;
        logic [1:0]  rs;
        logic        rdy;
        logic [3:0]  lk;
        logic [15:0] sp;
        model_reset();
        HRESETn = 1'b0;
        idle(4'b0000, 3);
        HRESETn = 1'b1;
        idle(4'b0000, 10);

        // Rotation among M1..M3 with SINGLE transfers.
        for (int i = 0; i < 8; i++) drv(4'b1110, 0, 2, 0, 1, 0, 0);
        idle(4'b0000, 3);

        // M2 owns, INCR8 burst with M1 waiting.
        idle(4'b0100, 3);
        drv(4'b0110, 0, 2, 5, 1, 0, 0);
        for (int i = 0; i < 7; i++) drv(4'b0110, 0, 3, 5, 1, 0, 0);
        idle(4'b0010, 4);

        // M1 locked pair of SINGLEs, M3 requesting.
        idle(4'b0010, 2);
        drv(4'b0010, 4'b0010, 0, 0, 1, 0, 0);
        drv(4'b1010, 4'b0010, 2, 0, 1, 0, 0);
        drv(4'b1010, 4'b0010, 2, 0, 1, 0, 0);
        idle(4'b1000, 4);

        // M3 transfer is split, then released.
        drv(4'b1000, 0, 2, 0, 1, 0, 0);
        drv(4'b1000, 0, 0, 0, 0, 3, 0);
        drv(4'b1000, 0, 0, 0, 1, 3, 0);
        idle(4'b1000, 4);
        drv(4'b1000, 0, 0, 0, 1, 0, 16'h0008);
        idle(4'b1000, 4);

        // Reset in the middle of an INCR16.
        idle(4'b0100, 3);
        drv(4'b0110, 0, 2, 7, 1, 0, 0);
        for (int i = 0; i < 4; i++) drv(4'b0110, 0, 3, 7, 1, 0, 0);
        #2 HRESETn = 1'b0;
        #1;
        check("rst_HGRANT", int'(HGRANT), 1 << DEF);
        check("rst_HMASTER", int'(HMASTER), DEF);
        check("rst_HMASTLOCK", int'(HMASTLOCK), 0);
        idle(4'b0110, 2);
        HRESETn = 1'b1;
        drv(4'b0110, 0, 2, 0, 1, 0, 0);
        idle(4'b0110, 4);

        // Randomized traffic.
        pend = 0;
        prs = 0;
        for (int c = 0; c < 3000; c++) begin
            if (pend) begin
                rdy = 1;
                rs = prs;
                pend = 0;
            end else if ($urandom_range(0, 19) == 0) begin
                rdy = 0;
                rs = 2'($urandom_range(1, 3));
                prs = rs;
                pend = 1;
            end else begin
                rdy = ($urandom_range(0, 4) != 0);
                rs = 0;
            end
            lk = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
            sp = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'h0;
            drv(4'($urandom), lk, 2'($urandom), 3'($urandom),
                rdy, rs, sp);
        end
        idle(4'b0000, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
